train_timer_bank: RTL

Parametrised bank of independent countdown timers for the train controller, the generalised replacement for the single 19-bit dwell/travel timer. Each channel is loaded with a tick count through a shared load port and runs in one-shot or auto-reload (periodic) mode, with per-channel pause and cancel. A shared prescaler sets the tick rate. Each channel drives a level `expired` flag and a one-cycle `done` pulse to the controller FSM.

---
 rtl/train_timer_pkg.sv | 12 +
 rtl/timer_channel.sv | 81 ++++++++
 rtl/train_timer_bank.sv | 87 ++++++++
 3 files changed

// File: rtl/train_timer_pkg.sv
// Shared defaults and mode encoding for the train controller timer bank.
package train_timer_pkg;

  localparam int DEF_WIDTH    = 19;
  localparam int DEF_CHANNELS = 4;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: count/reload/mode state plus registered expired and done flags.
module timer_channel
  import train_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             load_periodic_i,
  input  logic             pause_i,
  input  logic             cancel_i,
  output logic [WIDTH-1:0] count_o,
  output logic             expired_o,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  mode_e            mode_q, mode_d;
  logic             expired_q, expired_d;
  logic             done_q, done_d;

  // Next state: cancel beats load, load beats the tick decrement.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    if (cancel_i) begin
      count_d = {WIDTH{1'b0}};
      mode_d  = MODE_ONESHOT;
    end else if (load_i) begin
      count_d  = load_val_i;
      reload_d = load_val_i;
      // A zero load stays expired, so it must not become a periodic channel.
      if (load_periodic_i && (load_val_i != {WIDTH{1'b0}})) begin
        mode_d = MODE_PERIODIC;
      end else begin
        mode_d = MODE_ONESHOT;
      end
    end else if (tick_i && !pause_i && (count_q != {WIDTH{1'b0}})) begin
      if (count_q == WIDTH'(1)) begin
        done_d = 1'b1;
        if (mode_q == MODE_PERIODIC) begin
          count_d = reload_q;
        end else begin
          count_d = {WIDTH{1'b0}};
        end
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end else begin
      count_d = count_q;
    end
    expired_d = (count_d == {WIDTH{1'b0}});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= {WIDTH{1'b0}};
      reload_q  <= {WIDTH{1'b0}};
      mode_q    <= MODE_ONESHOT;
      expired_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      reload_q  <= reload_d;
      mode_q    <= mode_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  assign count_o   = count_q;
  assign expired_o = expired_q;
  assign done_o    = done_q;

endmodule

// File: rtl/train_timer_bank.sv
// Bank of countdown timers sharing one prescaler, load port and readback mux.
module train_timer_bank
  import train_timer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int PRESCALE = 1,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [CH_W-1:0]     load_ch,
  input  logic [WIDTH-1:0]    load_val,
  input  logic                load_periodic,
  input  logic [CHANNELS-1:0] pause,
  input  logic [CHANNELS-1:0] cancel,
  output logic [CHANNELS-1:0] expired,
  output logic [CHANNELS-1:0] done,
  output logic                busy,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [WIDTH-1:0]    rd_count
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]  pre_q, pre_d;
  logic             tick_s;
  logic [WIDTH-1:0] count_s [CHANNELS];
  logic [WIDTH-1:0] rd_sel_s;
  logic [WIDTH-1:0] rd_count_q;

  // Free-running prescaler; with PRESCALE=1 it sits at 0 and ticks every cycle.
  assign tick_s = (pre_q == PS_W'(PRESCALE - 1));

  always_comb begin
    if (tick_s) begin
      pre_d = {PS_W{1'b0}};
    end else begin
      pre_d = pre_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q <= {PS_W{1'b0}};
    end else begin
      pre_q <= pre_d;
    end
  end

  // Out-of-range load_ch values match no channel and are dropped.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk            (clk),
      .rst_n          (rst_n),
      .tick_i         (tick_s),
      .load_i         (load && (load_ch == CH_W'(g))),
      .load_val_i     (load_val),
      .load_periodic_i(load_periodic),
      .pause_i        (pause[g]),
      .cancel_i       (cancel[g]),
      .count_o        (count_s[g]),
      .expired_o      (expired[g]),
      .done_o         (done[g])
    );
  end

  always_comb begin
    rd_sel_s = {WIDTH{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      rd_sel_s = (rd_ch == CH_W'(c)) ? count_s[c] : rd_sel_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_count_q <= {WIDTH{1'b0}};
    end else begin
      rd_count_q <= rd_sel_s;
    end
  end

  assign rd_count = rd_count_q;
  assign busy     = |(~expired);

endmodule
